// File: rtl/fetch_stage_pkg.sv
// Shared PC-control encodings and fetch-stage defaults.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package fetch_stage_pkg;

    // Layout of the decoder's PC-control word: {J, B, cond[1:0]}
    localparam int WIDTH_PCCTRL = 4;
    localparam int PCCTRL_J     = 3;
    localparam int PCCTRL_B     = 2;

    // Branch condition encodings carried in pcctrl[1:0]
    localparam logic [1:0] PCCTRL_B_EQ  = 2'b00;
    localparam logic [1:0] PCCTRL_B_NE  = 2'b01;
    localparam logic [1:0] PCCTRL_B_LT  = 2'b10;
    localparam logic [1:0] PCCTRL_B_GEQ = 2'b11;

    // First fetch address and the NOP used to fill flushed/empty ID slots
    localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
    localparam logic [31:0] BUBBLE_INST_DEFAULT = 32'h0000_0000;

    // Evaluate a branch condition against the EX comparator flags
    function automatic logic cond_true(input logic [1:0] cond, input logic eq, input logic lt);
        logic res;
        res = 1'b0;
        case (cond)
            PCCTRL_B_EQ:  res = eq;
            PCCTRL_B_NE:  res = ~eq;
            PCCTRL_B_LT:  res = lt;
            PCCTRL_B_GEQ: res = ~lt;
            default:      res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/fetch_stage_branch_resolve.sv
// Resolves the EX-stage PC-control word into a taken/not-taken redirect.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; output follows inputs every cycle.
module fetch_stage_branch_resolve
    import fetch_stage_pkg::*;
(
    input  logic [WIDTH_PCCTRL-1:0] ex_pcctrl,
    input  logic                    ex_eq,
    input  logic                    ex_lt,
    output logic                    redirect
);

    // Jumps always redirect; branches only when their condition holds
    always_comb begin
        redirect = ex_pcctrl[PCCTRL_J]
                 | (ex_pcctrl[PCCTRL_B] & cond_true(ex_pcctrl[1:0], ex_eq, ex_lt));
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PC, drives a 1-cycle sync ROM, fills the IF/ID register.
// Latency: instruction at pc reaches ID 2 cycles later; taken redirect costs 2 bubbles.
// Backpressure: stall freezes PC, ROM output and IF/ID; a redirect overrides stall.
// Optional FETCH_PERF_CNT_EN adds perf_fetch/perf_flush event counters.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          XLEN        = 32,
    parameter logic [31:0] BUBBLE_INST = BUBBLE_INST_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic [WIDTH_PCCTRL-1:0] ex_pcctrl,
    input  logic                    ex_eq,
    input  logic                    ex_lt,
    input  logic [XLEN-1:0]         ex_target,
    output logic                    imem_en,
    output logic [XLEN-1:0]         imem_addr,
    input  logic [XLEN-1:0]         imem_rdata,
    output logic [XLEN-1:0]         id_pc,
    output logic [XLEN-1:0]         id_pc4,
    output logic [XLEN-1:0]         id_inst,
    output logic                    id_valid,
    output logic                    redirect
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]             perf_fetch,
    output logic [31:0]             perf_flush
`endif
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] pc_q;
    // Address whose ROM data is currently on imem_rdata, and whether it is real
    logic [XLEN-1:0] fa_q;
    logic            fv_q;

    // Targets are word aligned: no compressed instructions, and jalr bit0 is cleared too
    wire unused_target_lsbs = &{1'b0, ex_target[1:0]};

    fetch_stage_branch_resolve u_branch_resolve (
        .ex_pcctrl (ex_pcctrl),
        .ex_eq     (ex_eq),
        .ex_lt     (ex_lt),
        .redirect  (redirect)
    );

    // ROM is read at pc; disabling the read during stall keeps its output stable
    always_comb begin
        imem_addr = pc_q;
        imem_en   = ~stall | redirect;
    end

    // PC, fetch tracking and IF/ID register: reset > redirect > stall > advance
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q     <= RESET_PC;
            fa_q     <= '0;
            fv_q     <= 1'b0;
            id_pc    <= '0;
            id_pc4   <= PC_STEP;
            id_inst  <= BUBBLE_INST;
            id_valid <= 1'b0;
        end else if (redirect) begin
            pc_q     <= {ex_target[XLEN-1:2], 2'b00};
            fv_q     <= 1'b0;
            id_inst  <= BUBBLE_INST;
            id_valid <= 1'b0;
        end else if (!stall) begin
            pc_q     <= pc_q + PC_STEP;
            fa_q     <= pc_q;
            fv_q     <= 1'b1;
            id_pc    <= fa_q;
            id_pc4   <= fa_q + PC_STEP;
            id_inst  <= fv_q ? imem_rdata : BUBBLE_INST;
            id_valid <= fv_q;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Count valid instructions delivered to ID and taken redirects
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch <= '0;
            perf_flush <= '0;
        end else if (redirect) begin
            perf_flush <= perf_flush + 32'd1;
        end else if (!stall && fv_q) begin
            perf_fetch <= perf_fetch + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural 1-cycle ROM (word[i] = i+1).
// Latency: n/a.
// Backpressure: stall driven directly from stimulus.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [3:0]  ex_pcctrl;
    logic        ex_eq;
    logic        ex_lt;
    logic [31:0] ex_target;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic        id_valid;
    logic        redirect;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
`endif

    int checks   = 0;
    int failures = 0;

    fetch_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .ex_pcctrl  (ex_pcctrl),
        .ex_eq      (ex_eq),
        .ex_lt      (ex_lt),
        .ex_target  (ex_target),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .id_pc      (id_pc),
        .id_pc4     (id_pc4),
        .id_inst    (id_inst),
        .id_valid   (id_valid),
        .redirect   (redirect)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_flush (perf_flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read ROM: word at byte address a holds a/4 + 1
    always @(posedge clk) begin
        if (imem_en) imem_rdata <= {2'b00, imem_addr[31:2]} + 32'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                            input logic vld);
        check_eq({tag, ".id_pc"},    id_pc,    pc);
        check_eq({tag, ".id_pc4"},   id_pc4,   pc + 32'd4);
        check_eq({tag, ".id_inst"},  id_inst,  inst);
        check_eq({tag, ".id_valid"}, {31'd0, id_valid}, {31'd0, vld});
    endtask

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        ex_pcctrl = 4'b0000;
        ex_eq     = 1'b0;
        ex_lt     = 1'b0;
        ex_target = 32'd0;
        step();
        step();

        // Reset state
        check_id("rst", 32'd0, 32'd0, 1'b0);
        check_eq("rst.imem_addr", imem_addr, 32'd0);
        check_eq("rst.imem_en", {31'd0, imem_en}, 32'd1);
        rst_n = 1'b1;

        // Sequential fetch after reset release
        step();
        check_eq("seq1.id_valid", {31'd0, id_valid}, 32'd0);
        step();
        check_id("seq2", 32'd0, 32'd1, 1'b1);
        step();
        check_id("seq3", 32'd4, 32'd2, 1'b1);
        step();
        check_id("seq4", 32'd8, 32'd3, 1'b1);

        // Stall freezes everything for three edges
        stall = 1'b1;
        #1;
        check_eq("stall.imem_en", {31'd0, imem_en}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_id("stall", 32'd8, 32'd3, 1'b1);
            check_eq("stall.imem_addr", imem_addr, 32'd16);
        end
        stall = 1'b0;
        step();
        check_id("resume", 32'd12, 32'd4, 1'b1);
        check_eq("resume.imem_addr", imem_addr, 32'd20);

        // Taken BEQ to 0x100: two bubbles then target
        ex_pcctrl = 4'b0100;
        ex_eq     = 1'b1;
        ex_target = 32'h100;
        #1;
        check_eq("beq.redirect", {31'd0, redirect}, 32'd1);
        step();
        ex_pcctrl = 4'b0000;
        ex_eq     = 1'b0;
        #1;
        check_eq("beq.pc", imem_addr, 32'h100);
        check_eq("beq.b1.valid", {31'd0, id_valid}, 32'd0);
        check_eq("beq.b1.inst", id_inst, 32'd0);
        step();
        check_eq("beq.b2.valid", {31'd0, id_valid}, 32'd0);
        check_eq("beq.b2.inst", id_inst, 32'd0);
        step();
        check_id("beq.tgt", 32'h100, 32'h41, 1'b1);

        // Condition decode table without clocking
        ex_pcctrl = 4'b0101; ex_eq = 1'b1; #1;
        check_eq("bne.eq1", {31'd0, redirect}, 32'd0);
        ex_eq = 1'b0; #1;
        check_eq("bne.eq0", {31'd0, redirect}, 32'd1);
        ex_pcctrl = 4'b0110; ex_lt = 1'b1; #1;
        check_eq("blt.lt1", {31'd0, redirect}, 32'd1);
        ex_pcctrl = 4'b0011; ex_lt = 1'b0; #1;
        check_eq("nobranch.geq", {31'd0, redirect}, 32'd0);

        // BGE not taken keeps sequential fetch, then taken flips redirect
        ex_pcctrl = 4'b0111; ex_lt = 1'b1; #1;
        check_eq("bge.lt1", {31'd0, redirect}, 32'd0);
        step();
        check_id("bge.seq", 32'h104, 32'h42, 1'b1);
        ex_lt = 1'b0; #1;
        check_eq("bge.lt0", {31'd0, redirect}, 32'd1);
        ex_pcctrl = 4'b0000; ex_lt = 1'b0; #1;

        // Jump during stall: redirect wins, target low bits dropped
        stall     = 1'b1;
        ex_pcctrl = 4'b1000;
        ex_target = 32'h203;
        #1;
        check_eq("jstall.redirect", {31'd0, redirect}, 32'd1);
        check_eq("jstall.imem_en", {31'd0, imem_en}, 32'd1);
        step();
        stall = 1'b0;
        check_eq("jstall.pc", imem_addr, 32'h200);
        check_eq("jstall.valid", {31'd0, id_valid}, 32'd0);

        // Back-to-back jump to the top word, then PC wraps to 0
        ex_target = 32'hFFFF_FFFC;
        step();
        ex_pcctrl = 4'b0000;
        #1;
        check_eq("wrap.pc_top", imem_addr, 32'hFFFF_FFFC);
        step();
        check_eq("wrap.pc0", imem_addr, 32'd0);
        check_eq("wrap.b.valid", {31'd0, id_valid}, 32'd0);
        step();
        check_eq("wrap.id_pc", id_pc, 32'hFFFF_FFFC);
        check_eq("wrap.id_pc4", id_pc4, 32'd0);
        check_eq("wrap.id_inst", id_inst, 32'h4000_0000);
        check_eq("wrap.id_valid", {31'd0, id_valid}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
        check_eq("perf_fetch", perf_fetch, 32'd7);
        check_eq("perf_flush", perf_flush, 32'd3);
`endif

        // Reset asserted together with stall and a jump: reset wins
        rst_n     = 1'b0;
        stall     = 1'b1;
        ex_pcctrl = 4'b1000;
        ex_target = 32'h400;
        step();
        check_id("rst2", 32'd0, 32'd0, 1'b0);
        ex_pcctrl = 4'b0000;
        #1;
        check_eq("rst2.pc", imem_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        check_eq("rst2.perf_fetch", perf_fetch, 32'd0);
        check_eq("rst2.perf_flush", perf_flush, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
